au_arbiter: RTL and testbench

- Shares one combinational arithmetic unit (au: add / sub / paddsw, 4-bit Cmd, 16-bit operands, Result + cout) between two requesters, e.g. the EX stage and the address-generation path.
- Arbitrates with a round-robin or fixed-priority policy and registers the winning operands into an issue stage that drives the AU.
- Captures the AU output one cycle later and returns it to the originating requester as a one-cycle response pulse.
- Fully pipelined: one operation accepted per cycle.

---
 rtl/au_arbiter.sv | 168 ++++++++++++++++
 tb/tb_au_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/au_arbiter.sv
// Two-requester front end for one shared combinational AU: round-robin or fixed-priority
// arbitration, a registered issue stage driving the AU, and a registered per-requester response.
module au_arbiter #(
  parameter int DATA_W     = 16,
  parameter int CMD_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_vld,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_rdy,
  output logic              rsp0_vld,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_cout,

  input  logic              req1_vld,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_rdy,
  output logic              rsp1_vld,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_cout,

  output logic [CMD_W-1:0]  au_cmd,
  output logic [DATA_W-1:0] au_a,
  output logic [DATA_W-1:0] au_b,
  input  logic [DATA_W-1:0] au_result,
  input  logic              au_cout
);

  logic              gnt0_s, gnt1_s;

  logic              last_gnt_d, last_gnt_q;
  logic              s1_vld_d, s1_vld_q;
  logic              s1_id_d, s1_id_q;
  logic [CMD_W-1:0]  s1_cmd_d, s1_cmd_q;
  logic [DATA_W-1:0] s1_a_d, s1_a_q;
  logic [DATA_W-1:0] s1_b_d, s1_b_q;

  logic              rsp0_vld_d, rsp0_vld_q;
  logic [DATA_W-1:0] rsp0_result_d, rsp0_result_q;
  logic              rsp0_cout_d, rsp0_cout_q;
  logic              rsp1_vld_d, rsp1_vld_q;
  logic [DATA_W-1:0] rsp1_result_d, rsp1_result_q;
  logic              rsp1_cout_d, rsp1_cout_q;

  // Grant selection; last_gnt_q names the previous winner, so under contention the other side wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case ({req1_vld, req0_vld})
      2'b01: gnt0_s = 1'b1;
      2'b10: gnt1_s = 1'b1;
      2'b11: begin
        if (FIXED_PRIO != 0) begin
          gnt0_s = 1'b1;
        end else if (last_gnt_q) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  assign req0_rdy = gnt0_s;
  assign req1_rdy = gnt1_s;

  // Next-state for the grant history and the issue stage; operands hold when nothing is granted.
  always_comb begin
    last_gnt_d = last_gnt_q;
    s1_vld_d   = gnt0_s | gnt1_s;
    s1_id_d    = s1_id_q;
    s1_cmd_d   = s1_cmd_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (gnt0_s) begin
      last_gnt_d = 1'b0;
      s1_id_d    = 1'b0;
      s1_cmd_d   = req0_cmd;
      s1_a_d     = req0_a;
      s1_b_d     = req0_b;
    end else if (gnt1_s) begin
      last_gnt_d = 1'b1;
      s1_id_d    = 1'b1;
      s1_cmd_d   = req1_cmd;
      s1_a_d     = req1_a;
      s1_b_d     = req1_b;
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // Response stage: route the AU output back to whichever requester owns the issued op.
  always_comb begin
    rsp0_vld_d    = s1_vld_q & ~s1_id_q;
    rsp1_vld_d    = s1_vld_q &  s1_id_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_cout_d   = rsp0_cout_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_cout_d   = rsp1_cout_q;
    if (rsp0_vld_d) begin
      rsp0_result_d = au_result;
      rsp0_cout_d   = au_cout;
    end else begin
      rsp0_cout_d   = rsp0_cout_q;
    end
    if (rsp1_vld_d) begin
      rsp1_result_d = au_result;
      rsp1_cout_d   = au_cout;
    end else begin
      rsp1_cout_d   = rsp1_cout_q;
    end
  end

  // State registers; last_gnt resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_q    <= 1'b1;
      s1_vld_q      <= 1'b0;
      s1_id_q       <= 1'b0;
      s1_cmd_q      <= {CMD_W{1'b0}};
      s1_a_q        <= {DATA_W{1'b0}};
      s1_b_q        <= {DATA_W{1'b0}};
      rsp0_vld_q    <= 1'b0;
      rsp0_result_q <= {DATA_W{1'b0}};
      rsp0_cout_q   <= 1'b0;
      rsp1_vld_q    <= 1'b0;
      rsp1_result_q <= {DATA_W{1'b0}};
      rsp1_cout_q   <= 1'b0;
    end else begin
      last_gnt_q    <= last_gnt_d;
      s1_vld_q      <= s1_vld_d;
      s1_id_q       <= s1_id_d;
      s1_cmd_q      <= s1_cmd_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      rsp0_vld_q    <= rsp0_vld_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_cout_q   <= rsp0_cout_d;
      rsp1_vld_q    <= rsp1_vld_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_cout_q   <= rsp1_cout_d;
    end
  end

  // AU inputs are forced to zero when the issue stage is empty.
  assign au_cmd = s1_vld_q ? s1_cmd_q : {CMD_W{1'b0}};
  assign au_a   = s1_vld_q ? s1_a_q   : {DATA_W{1'b0}};
  assign au_b   = s1_vld_q ? s1_b_q   : {DATA_W{1'b0}};

  assign rsp0_vld    = rsp0_vld_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_cout   = rsp0_cout_q;
  assign rsp1_vld    = rsp1_vld_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_cout   = rsp1_cout_q;

endmodule

// File: tb/tb_au_arbiter.sv
// Bench for au_arbiter: a round-robin and a fixed-priority instance share stimulus; each has its
// own behavioural AU, and a grant-ordered scoreboard predicts rdy, AU drive and responses.
module tb_au_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_vld, req1_vld;
  logic [3:0]  req0_cmd, req1_cmd;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;

  logic        rr_req0_rdy, rr_rsp0_vld, rr_rsp0_cout, rr_req1_rdy, rr_rsp1_vld, rr_rsp1_cout;
  logic [15:0] rr_rsp0_result, rr_rsp1_result, rr_au_a, rr_au_b, rr_au_result;
  logic [3:0]  rr_au_cmd;
  logic        rr_au_cout;

  logic        fp_req0_rdy, fp_rsp0_vld, fp_rsp0_cout, fp_req1_rdy, fp_rsp1_vld, fp_rsp1_cout;
  logic [15:0] fp_rsp0_result, fp_rsp1_result, fp_au_a, fp_au_b, fp_au_result;
  logic [3:0]  fp_au_cmd;
  logic        fp_au_cout;

  // Shared AU behaviour: 0 = add, 2 = sub (cout = borrow), 8 = saturating signed add.
  function automatic logic [16:0] au_f(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    case (cmd)
      4'h0: au_f = {1'b0, a} + {1'b0, b};
      4'h2: au_f = {1'b0, a} - {1'b0, b};
      4'h8: begin
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) au_f = s[16] ? 17'h08000 : 17'h07FFF;
        else au_f = {1'b0, s[15:0]};
      end
      default: au_f = 17'h00000;
    endcase
  endfunction

  assign {rr_au_cout, rr_au_result} = au_f(rr_au_cmd, rr_au_a, rr_au_b);
  assign {fp_au_cout, fp_au_result} = au_f(fp_au_cmd, fp_au_a, fp_au_b);

  au_arbiter #(.DATA_W(16), .CMD_W(4), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b), .req0_rdy(rr_req0_rdy),
    .rsp0_vld(rr_rsp0_vld), .rsp0_result(rr_rsp0_result), .rsp0_cout(rr_rsp0_cout),
    .req1_vld(req1_vld), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b), .req1_rdy(rr_req1_rdy),
    .rsp1_vld(rr_rsp1_vld), .rsp1_result(rr_rsp1_result), .rsp1_cout(rr_rsp1_cout),
    .au_cmd(rr_au_cmd), .au_a(rr_au_a), .au_b(rr_au_b), .au_result(rr_au_result), .au_cout(rr_au_cout)
  );

  au_arbiter #(.DATA_W(16), .CMD_W(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b), .req0_rdy(fp_req0_rdy),
    .rsp0_vld(fp_rsp0_vld), .rsp0_result(fp_rsp0_result), .rsp0_cout(fp_rsp0_cout),
    .req1_vld(req1_vld), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b), .req1_rdy(fp_req1_rdy),
    .rsp1_vld(fp_rsp1_vld), .rsp1_result(fp_rsp1_result), .rsp1_cout(fp_rsp1_cout),
    .au_cmd(fp_au_cmd), .au_a(fp_au_a), .au_b(fp_au_b), .au_result(fp_au_result), .au_cout(fp_au_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [16:0] val;
  } exp_t;

  exp_t        q_rr[$];
  exp_t        q_fp[$];
  int          last_win [2];
  logic [16:0] hold [2][2];
  logic [35:0] au_exp [2];
  int          cyc;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rules; -1 means nobody is granted.
  function automatic int winner(input logic v0, input logic v1, input int last, input bit fixed);
    if (v0 && v1) return fixed ? 0 : ((last == 1) ? 0 : 1);
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_edge(input int m, input int g);
    exp_t e;
    if (!rst_n) begin
      if (m == 0) q_rr.delete(); else q_fp.delete();
      hold[m][0]  = 17'h0;
      hold[m][1]  = 17'h0;
      last_win[m] = 1;
      au_exp[m]   = 36'h0;
    end else if (g >= 0) begin
      e.due = cyc + 1;
      e.id  = g;
      e.val = (g == 0) ? au_f(req0_cmd, req0_a, req0_b) : au_f(req1_cmd, req1_a, req1_b);
      if (m == 0) q_rr.push_back(e); else q_fp.push_back(e);
      last_win[m] = g;
      au_exp[m]   = (g == 0) ? {req0_cmd, req0_a, req0_b} : {req1_cmd, req1_a, req1_b};
    end else begin
      au_exp[m]   = 36'h0;
    end
  endtask

  task automatic check_dut(input int m, input logic o0v, input logic o1v,
                           input logic [16:0] o0, input logic [16:0] o1, input logic [35:0] oau);
    exp_t  h;
    logic  e0, e1;
    string p;
    e0 = 1'b0;
    e1 = 1'b0;
    p  = (m == 0) ? "rr" : "fp";
    if (m == 0 && q_rr.size() > 0 && q_rr[0].due == cyc) begin
      h = q_rr.pop_front();
      e0 = (h.id == 0); e1 = (h.id == 1); hold[0][h.id] = h.val;
    end else if (m == 1 && q_fp.size() > 0 && q_fp[0].due == cyc) begin
      h = q_fp.pop_front();
      e0 = (h.id == 0); e1 = (h.id == 1); hold[1][h.id] = h.val;
    end
    chk({p, ".rsp0_vld"}, {63'h0, o0v}, {63'h0, e0});
    chk({p, ".rsp1_vld"}, {63'h0, o1v}, {63'h0, e1});
    chk({p, ".rsp0_data"}, {47'h0, o0}, {47'h0, hold[m][0]});
    chk({p, ".rsp1_data"}, {47'h0, o1}, {47'h0, hold[m][1]});
    chk({p, ".au_drive"}, {28'h0, oau}, {28'h0, au_exp[m]});
  endtask

  // One clock: drive at the falling edge, check rdy, model the rising edge, check outputs after it.
  task automatic cycle(input logic rst, input logic v0, input logic [3:0] c0, input logic [15:0] a0,
                       input logic [15:0] b0, input logic v1, input logic [3:0] c1,
                       input logic [15:0] a1, input logic [15:0] b1);
    int g_rr, g_fp;
    rst_n = rst;
    req0_vld = v0; req0_cmd = c0; req0_a = a0; req0_b = b0;
    req1_vld = v1; req1_cmd = c1; req1_a = a1; req1_b = b1;
    #1;
    g_rr = winner(v0, v1, last_win[0], 1'b0);
    g_fp = winner(v0, v1, last_win[1], 1'b1);
    chk("rr.req0_rdy", {63'h0, rr_req0_rdy}, {63'h0, (g_rr == 0)});
    chk("rr.req1_rdy", {63'h0, rr_req1_rdy}, {63'h0, (g_rr == 1)});
    chk("fp.req0_rdy", {63'h0, fp_req0_rdy}, {63'h0, (g_fp == 0)});
    chk("fp.req1_rdy", {63'h0, fp_req1_rdy}, {63'h0, (g_fp == 1)});
    @(posedge clk);
    cyc++;
    model_edge(0, g_rr);
    model_edge(1, g_fp);
    @(negedge clk);
    check_dut(0, rr_rsp0_vld, rr_rsp1_vld, {rr_rsp0_cout, rr_rsp0_result},
              {rr_rsp1_cout, rr_rsp1_result}, {rr_au_cmd, rr_au_a, rr_au_b});
    check_dut(1, fp_rsp0_vld, fp_rsp1_vld, {fp_rsp0_cout, fp_rsp0_result},
              {fp_rsp1_cout, fp_rsp1_result}, {fp_au_cmd, fp_au_a, fp_au_b});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] av, bv;
    logic [3:0]  cr0, cr1;
    tests = 0; fails = 0; cyc = 0;
    last_win[0] = 1; last_win[1] = 1;
    for (int m = 0; m < 2; m++) begin
      hold[m][0] = 17'h0; hold[m][1] = 17'h0; au_exp[m] = 36'h0;
    end

    // Reset, with a request pending during reset that must never respond.
    cycle(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);
    cycle(1'b0, 1'b1, 4'h0, 16'd7, 16'd7, 1'b0, 4'h0, 16'h0, 16'h0);
    idle(2);

    // Single requesters: add on req0, sub on req1, saturating add on req0.
    cycle(1'b1, 1'b1, 4'h0, 16'd20000, 16'd3, 1'b0, 4'h0, 16'h0, 16'h0);
    idle(3);
    cycle(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 4'h2, 16'd5, 16'd7);
    idle(3);
    cycle(1'b1, 1'b1, 4'h8, 16'h7FF0, 16'h0100, 1'b0, 4'h0, 16'h0, 16'h0);
    idle(2);

    // Sustained contention for 4 cycles, then req0 drops while req1 stays.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'h0, 16'd1, 16'd1, 1'b1, 4'h0, 16'd10, 16'd10);
    cycle(1'b1, 1'b0, 4'h0, 16'd1, 16'd1, 1'b1, 4'h0, 16'd10, 16'd10);
    idle(3);

    // Grant to req0, reset on the next edge, then contention goes to req0 again.
    cycle(1'b1, 1'b1, 4'h0, 16'd100, 16'd1, 1'b0, 4'h0, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 4'h0, 16'd2, 16'd2, 1'b1, 4'h0, 16'd3, 16'd3);
    idle(3);

    // Randomised sweep with occasional resets.
    av = 16'd20000;
    bv = 16'd0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2)) 0: cr0 = 4'h0; 1: cr0 = 4'h2; default: cr0 = 4'h8; endcase
      case ($urandom_range(0, 2)) 0: cr1 = 4'h0; 1: cr1 = 4'h2; default: cr1 = 4'h8; endcase
      cycle(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), cr0, av, bv,
            1'($urandom_range(0, 1)), cr1, av + 16'd7, bv + 16'd3);
      av = av + 16'd14;
      bv = bv + 16'd6;
    end
    idle(3);
    chk("rr.scoreboard_empty", 64'(q_rr.size()), 64'h0);
    chk("fp.scoreboard_empty", 64'(q_fp.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
